// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path.
package riscv_pkg;

  // Controller state encodings, also exported on the debug state port.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_t;

  // Supported major opcodes.
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  // result_src: registered ALU output, memory read data, live ALU result.
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  // alu_src_a: PC, PC of the current instruction, rs1.
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  // alu_src_b: rs2, immediate, constant four.
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // alu_op: add, subtract (branch compare), decode from funct fields.
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: Moore FSM driving datapath enables and selects.
module main_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;

  // State register with synchronous reset overriding any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecuteR;
          OpIAlu:     state_d = StExecuteI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        if (op == OpLw) begin
          state_d = StMemRead;
        end else if (op == OpSw) begin
          state_d = StMemWrite;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Output decode from state; mem_ready, zero and op gate only the listed strobes.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    alu_op     = AluAdd;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAluRes;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        illegal_op = !(op == OpLw || op == OpSw || op == OpR || op == OpIAlu ||
                       op == OpBeq || op == OpJal);
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: begin
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluFunct;
      end
      StExecuteI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluFunct;
      end
      StAluWb: begin
        reg_write = 1'b1;
      end
      StBeq: begin
        alu_src_a = SrcARs1;
        alu_op    = AluSub;
        pc_write  = zero;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Strobes must stay quiet while reset is held, whatever state we are leaving.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule
